seg7_scan_counter: RTL and testbench
====================================

// Module: seg7_scan_counter
// PURPOSE
//  Parametrised multi-digit up/down counter with a time-multiplexed 7-segment display driver.
//  A prescaler divides clk down to a step tick. On each tick the NUM_DIGITS-digit value steps by one, in hex or BCD.
//  A scan counter drives one digit at a time onto a shared segment bus, with a one-hot digit enable.
//  Sits at the top level and feeds uo_out (segments) and uio_out (digit enables).
// PARAMETERS
//  TICK_DIV    10_000_000  clk cycles per count step; must be >= 2
//  SCAN_DIV    1_000       clk cycles each digit stays enabled; must be >= 1
//  NUM_DIGITS  4           digits in value and scan, 1..8
// PORTS
//  clk       in   1              clock
//  rst_n     in   1              reset, asynchronous, active-low
//  en        in   1              1 = prescaler runs; 0 = freeze prescaler and value (scan keeps running)
//  up_dn     in   1              1 = count up, 0 = count down
//  mode_dec  in   1              1 = BCD (digits 0..9), 0 = hex (digits 0..F)
//  load      in   1              synchronous load strobe
//  load_val  in   4*NUM_DIGITS   value to load, digit 0 in [3:0]
//  seg       out  7              active-high segments {g,f,e,d,c,b,a}, registered
//  dig_en    out  NUM_DIGITS     one-hot, active-high digit enable, registered
//  wrap      out  1              one-cycle pulse when the value wraps
// BEHAVIOUR
//  Reset:
//   - value = 0, prescaler = 0, scan counter = 0, digit index = 0.
//   - seg = 7'h00, dig_en = 1 (digit 0), wrap = 0.
//  Prescaler:
//   - Counts 0..TICK_DIV-1 while en = 1; tick asserts on the cycle the count equals TICK_DIV-1, then the count returns to 0.
//   - One step occurs every exactly TICK_DIV cycles.
//  Step on tick (up):
//   - Digit 0 increments; a digit at its max (9 in BCD, F in hex) goes to 0 and carries.
//   - When all digits are at max, the value becomes 0 and wrap = 1 for one cycle.
//  Step on tick (down):
//   - Digit 0 decrements; a digit at 0 goes to max and borrows.
//   - When all digits are 0, the value becomes all-max and wrap = 1.
//  BCD with a stale digit > 9 (after a mode change):
//   - Treated as max: stepping up gives 0 plus carry; stepping down gives 9.
//  Load:
//   - Has priority over tick in the same cycle.
//   - Value <= load_val; in BCD any loaded digit > 9 is clamped to 9.
//   - Prescaler is cleared to 0; wrap is not asserted.
//   - Load acts even when en = 0.
//  Changes to up_dn and mode_dec take effect at the next tick; there is no glitching of the value.
//  Scan:
//   - Every SCAN_DIV cycles the digit index advances and wraps from NUM_DIGITS-1 to 0.
//   - seg and dig_en update together one clk after the index changes, so a pair never mixes digits.
//  Decode: 0-9 and A-F in the usual glyphs (b, d lower-case).
//  Value updates show on the next scan register update; the display latency is 1 clk.
//  The arithmetic wraps to the digit width; no counter overflows because the widths come from $clog2 of each DIV.
// CONFIGURATION
//  SEG7_LZ_BLANK_EN:
//   - Defined: leading-zero blanking. Scanning digit i gives seg = 0 when every digit from i up to NUM_DIGITS-1 is 0.
//     Digit 0 is never blanked. dig_en is unaffected.
//   - Undefined: every digit always shows its glyph.
// STRUCTURE
//  Package seg7_pkg:
//   - localparam glyph table SEG7_GLYPH[16] (7-bit, {g..a}).
//   - SEG7_BLANK = 7'h00.
//   - Function digit_max(mode_dec) returning 4'd9 or 4'd15.
//  Sub-module seg7_decode: combinational 4-bit digit to 7-bit glyph, one instance on the muxed digit.
//  Everything else (prescaler, BCD/hex digit chain, scan, output registers) stays in this module.
// TESTING (TICK_DIV=4, SCAN_DIV=2, NUM_DIGITS=2 unless noted)
//  1. Reset then en=1, up, hex: the value reaches 8'h01 after 4 clk, 8'h10 after 64 clk.
//     At FF->00, wrap is high for exactly 1 clk.
//  2. BCD up from load 8'h98: ticks give 99, then 00 with wrap=1.
//     Down from 00 gives 99 with wrap=1.
//  3. Load 8'hFA in BCD: value = 8'h99.
//     Load asserted on the tick cycle: value = load_val, no step, next tick 4 clk later.
//  4. Scan: dig_en sequence 01,01,10,10,01...; seg matches the glyph of the enabled digit on the same cycle.
//     Value 8'h3C in hex gives digit 0 glyph 7'h39, digit 1 glyph 7'h4F.
//  5. en=0 for 20 clk: the value and prescaler hold and dig_en keeps scanning.
//     Async rst_n low mid-tick: all outputs go to reset values immediately.
//  6. With SEG7_LZ_BLANK_EN, NUM_DIGITS=4, value 16'h0050: digits 3 and 2 give seg=0, digits 1 and 0 show 5 and 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan counter: glyph table, blank code and digit limit.
package seg7_pkg;

  // Glyphs are {g,f,e,d,c,b,a}, active high; b and d use lower-case shapes.
  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG7_BLANK = 7'h00;

  function automatic logic [3:0] digit_max(input logic mode_dec);
    return mode_dec ? 4'd9 : 4'd15;
  endfunction

endpackage

// File: rtl/seg7_scan_counter_decode.sv
// Combinational hex digit to 7-segment glyph lookup.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] glyph
);

  always_comb glyph = SEG7_GLYPH[digit];

endmodule

// File: rtl/seg7_scan_counter.sv
// Multi-digit hex/BCD up/down counter with a time-multiplexed 7-segment driver.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_counter
  import seg7_pkg::*;
#(
  parameter int TICK_DIV   = 10_000_000,
  parameter int SCAN_DIV   = 1_000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    mode_dec,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = 1;

  logic [PW-1:0]           pre;
  logic [SW-1:0]           scan_cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] value;
  logic [4*NUM_DIGITS-1:0] value_step;
  logic [4*NUM_DIGITS-1:0] value_load;
  logic                    step_wrap;
  logic                    tick;
  logic [3:0]              cur_digit;
  logic [6:0]              glyph;
  logic                    blank;

  assign tick = en && (pre == PW'(TICK_DIV - 1));

  // Ripple carry/borrow chain; a stale BCD digit above 9 behaves as the max digit.
  always_comb begin : step_chain
    logic [3:0] d;
    logic [3:0] mx;
    logic       c;
    d          = 4'd0;
    mx         = digit_max(mode_dec);
    c          = 1'b1;
    value_step = value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = value[4*i +: 4];
      if (c) begin
        if (up_dn) begin
          if (d >= mx) begin
            d = 4'd0;
          end else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            d = mx;
          end else if (d > mx) begin
            d = mx;
            c = 1'b0;
          end else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
      end
      value_step[4*i +: 4] = d;
    end
    step_wrap = c;
  end

  always_comb begin
    value_load = load_val;
    if (mode_dec) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (load_val[4*i +: 4] > 4'd9) value_load[4*i +: 4] = 4'd9;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      value <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        value <= value_load;
        pre   <= '0;
      end else if (en) begin
        if (tick) begin
          pre   <= '0;
          value <= value_step;
          wrap  <= step_wrap;
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  assign cur_digit = value[{idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .digit (cur_digit),
    .glyph (glyph)
  );

`ifdef SEG7_LZ_BLANK_EN
  // Blank when this digit and every more-significant digit are zero.
  always_comb begin
    blank = 1'b0;
    if (idx != '0) begin
      blank = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((i >= int'(idx)) && (value[4*i +: 4] != 4'd0)) blank = 1'b0;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  // seg and dig_en share one register stage so each pair belongs to one digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= SEG7_BLANK;
      dig_en <= DIG_ONE;
    end else begin
      seg    <= blank ? SEG7_BLANK : glyph;
      dig_en <= DIG_ONE << idx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Self-checking bench for seg7_scan_counter (2-digit and 4-digit instances).
module tb_seg7_scan_counter;

  localparam int TD = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b1;
  logic        mode_dec = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic        load4 = 1'b0;
  logic [15:0] load_val4 = 16'h0000;
  logic [6:0]  seg;
  logic [1:0]  dig_en;
  logic        wrap;
  logic [6:0]  seg4;
  logic [3:0]  dig_en4;
  logic        wrap4;

  int n_checks = 0;
  int n_fail = 0;
  int edges;
  logic [10:0] exp_q[$];

  typedef struct {
    string       name;
    logic        mode;
    logic [7:0]  lval;
    logic [15:0] expv;
  } load_vec_t;

  seg7_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD), .NUM_DIGITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .mode_dec(mode_dec),
    .load(load), .load_val(load_val), .seg(seg), .dig_en(dig_en), .wrap(wrap)
  );

  seg7_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD), .NUM_DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .mode_dec(mode_dec),
    .load(load4), .load_val(load_val4), .seg(seg4), .dig_en(dig_en4), .wrap(wrap4)
  );

  // Clock, and a count of rising edges since reset release for the scan model.
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i);
    logic [6:0] g;
    g = glyph_of(v[4*i +: 4]);
`ifdef SEG7_LZ_BLANK_EN
    if ((i != 0) && ((v >> (4*i)) == 16'd0)) g = 7'h00;
`endif
    return g;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Push the expected {dig_en, seg} for the next ns samples, then pop and compare.
  task automatic check_disp(input string name, input int sel, input logic [15:0] v, input int ns);
    int n, k, i;
    logic [10:0] e, act;
    n = (sel != 0) ? 4 : 2;
    for (int j = 0; j < ns; j++) begin
      k = edges + 1 + j;
      i = ((k - 1) / SD) % n;
      exp_q.push_back({4'(1 << i), exp_seg(v, i)});
    end
    for (int j = 0; j < ns; j++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      act = (sel != 0) ? {dig_en4, seg4} : {2'b00, dig_en, seg};
      cmp(name, 32'(act), 32'(e));
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load_val = v;
    load = 1'b1;
    clocks(1);
    load = 1'b0;
  endtask

  task automatic wrap_window(input string name, input int len, input int at);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      cmp(name, 32'(wrap), 32'(c == at));
    end
  endtask

  load_vec_t lv[4];

  initial begin
    lv[0] = '{"load bcd clamp FA", 1'b1, 8'hFA, 16'h0099};
    lv[1] = '{"load bcd clamp 9C", 1'b1, 8'h9C, 16'h0099};
    lv[2] = '{"load bcd 47",       1'b1, 8'h47, 16'h0047};
    lv[3] = '{"load hex 3C",       1'b0, 8'h3C, 16'h003C};

    repeat (2) @(negedge clk);
    cmp("reset seg", 32'(seg), 32'h00);
    cmp("reset dig_en", 32'(dig_en), 32'h1);
    cmp("reset wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;

    // Hex up from reset: 01 after 4 clk, 10 after 64 clk, wrap at FF->00.
    en = 1'b1; clocks(4); en = 1'b0;
    check_disp("hex up 01", 0, 16'h01, 4);
    en = 1'b1; clocks(60); en = 1'b0;
    check_disp("hex up 10", 0, 16'h10, 4);
    en = 1'b1;
    wrap_window("hex wrap pulse", 962, 960);
    en = 1'b0;
    check_disp("hex after wrap", 0, 16'h00, 4);

    // Table-driven loads, including BCD clamping.
    for (int t = 0; t < 4; t++) begin
      mode_dec = lv[t].mode;
      do_load(lv[t].lval);
      check_disp(lv[t].name, 0, lv[t].expv, 8);
    end

    // BCD up through 99 -> 00 and down 00 -> 99.
    mode_dec = 1'b1; up_dn = 1'b1;
    do_load(8'h98);
    en = 1'b1; clocks(4); en = 1'b0;
    check_disp("bcd up 99", 0, 16'h99, 4);
    en = 1'b1; wrap_window("bcd up wrap", 4, 4); en = 1'b0;
    clocks(1); cmp("bcd up wrap one clk", 32'(wrap), 32'h0);
    check_disp("bcd up 00", 0, 16'h00, 4);
    up_dn = 1'b0;
    en = 1'b1; wrap_window("bcd down wrap", 4, 4); en = 1'b0;
    clocks(1); cmp("bcd down wrap one clk", 32'(wrap), 32'h0);
    check_disp("bcd down 99", 0, 16'h99, 4);

    // Load on the tick cycle wins and restarts the prescaler.
    up_dn = 1'b1;
    do_load(8'h10);
    en = 1'b1; clocks(3);
    load_val = 8'h42; load = 1'b1; clocks(1); load = 1'b0;
    cmp("load on tick no wrap", 32'(wrap), 32'h0);
    clocks(3); en = 1'b0;
    check_disp("load on tick value", 0, 16'h42, 4);
    en = 1'b1; clocks(1); en = 1'b0;
    check_disp("tick 4 clk after load", 0, 16'h43, 4);

    // Stale hex digits stepped in BCD mode.
    mode_dec = 1'b0; do_load(8'h3C); mode_dec = 1'b1; up_dn = 1'b1;
    en = 1'b1; clocks(4); en = 1'b0;
    check_disp("stale up", 0, 16'h40, 4);
    mode_dec = 1'b0; do_load(8'hA0); mode_dec = 1'b1; up_dn = 1'b0;
    en = 1'b1; clocks(4); en = 1'b0;
    check_disp("stale down", 0, 16'h99, 4);

    // en=0 freezes value and prescaler while scanning continues.
    mode_dec = 1'b0; up_dn = 1'b1;
    do_load(8'h55);
    en = 1'b1; clocks(2); en = 1'b0;
    check_disp("en low hold", 0, 16'h55, 20);
    en = 1'b1; clocks(1); en = 1'b0;
    check_disp("prescaler held", 0, 16'h55, 4);
    en = 1'b1; clocks(1); en = 1'b0;
    check_disp("step after hold", 0, 16'h56, 4);

    // Asynchronous reset between clock edges.
    en = 1'b1; clocks(2);
    #2 rst_n = 1'b0;
    #1;
    cmp("async rst seg", 32'(seg), 32'h00);
    cmp("async rst dig_en", 32'(dig_en), 32'h1);
    cmp("async rst wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    check_disp("after async rst", 0, 16'h00, 4);

    // Four-digit instance, value 0050 (blanking depends on the build).
    load_val4 = 16'h0050; load4 = 1'b1; clocks(1); load4 = 1'b0;
    check_disp("4 digit 0050", 1, 16'h0050, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
